// File: rtl/hold_timer_pkg.sv
// -----------------------------------------------------------------------------
// hold_timer_pkg
// Shared types and default constants for the hold timer and its prescaler.
//   state_t          one-hot timer state encoding (T_IDLE, T_RUN, T_DONE)
//   DEF_WIDTH        default counter width in bits
//   DEF_HOLD_CYCLES  default hold interval in counter ticks
//   DEF_PRESC_DIV    default clock cycles per tick when the prescaler is built
// -----------------------------------------------------------------------------
package hold_timer_pkg;

    typedef enum int unsigned {
        T_IDLE = 32'd1,
        T_RUN  = 32'd2,
        T_DONE = 32'd4
    } state_t;

    localparam int unsigned DEF_WIDTH       = 32'd8;
    localparam int unsigned DEF_HOLD_CYCLES = 32'd10;
    localparam int unsigned DEF_PRESC_DIV   = 32'd4;

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Emits a one-cycle TICK once every DIV clocks. CLR restarts the period so the
// first tick after a clear arrives exactly DIV clocks later.
// Ports:
//   CLK      in   clock, rising edge
//   N_RESET  in   asynchronous active-low reset
//   CLR      in   synchronous restart of the division period
//   TICK     out  registered one-cycle tick
// Only instantiated when HOLD_TIMER_PRESCALE_EN is defined.
// -----------------------------------------------------------------------------
module tick_prescaler
    import hold_timer_pkg::*;
#(
    parameter int unsigned DIV = DEF_PRESC_DIV
) (
    input  logic CLK,
    input  logic N_RESET,
    input  logic CLR,
    output logic TICK
);

    localparam int unsigned CW = ($clog2(DIV) > 0) ? $clog2(DIV) : 32'd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    if (DIV < 32'd2) begin : g_bad_div
        $error("tick_prescaler: DIV must be 2 or more");
    end

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          tick_r;

    // Next period count: restart on clear, wrap after the last clock of a period.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (CLR) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Period counter and registered tick; the tick is high while the counter
    // sits on its last value so the consumer advances on the following edge.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            cnt_r  <= CNT_ZERO;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == CNT_LAST);
        end
    end

    assign TICK = tick_r;

endmodule

// File: rtl/hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
// Hold-interval timer paired with the Moore handshake controller. START from
// the controller launches a count of HOLD_CYCLES ticks; READY then stays high
// until the controller clears the timer with RESET.
// Ports:
//   CLK      in   clock, rising edge
//   N_RESET  in   asynchronous active-low reset
//   RESET    in   synchronous clear (level), overrides START
//   START    in   launch request, accepted only in T_IDLE
//   READY    out  high while the interval has expired (T_DONE)
//   BUSY     out  high while counting (T_RUN)
//   COUNT    out  current tick count
// Build option: HOLD_TIMER_PRESCALE_EN inserts a prescaler so one tick lasts
// PRESC_DIV clocks; without it every clock is a tick.
// -----------------------------------------------------------------------------
module hold_timer
    import hold_timer_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned PRESC_DIV   = DEF_PRESC_DIV
) (
    input  logic             CLK,
    input  logic             N_RESET,
    input  logic             RESET,
    input  logic             START,
    output logic             READY,
    output logic             BUSY,
    output logic [WIDTH-1:0] COUNT
);

    localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(32'd0);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(32'd1);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(HOLD_CYCLES - 32'd1);
    localparam logic [WIDTH-1:0] CNT_HOLD = WIDTH'(HOLD_CYCLES);

    if ((HOLD_CYCLES < 32'd1) ||
        (64'(HOLD_CYCLES) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_hold
        $error("hold_timer: HOLD_CYCLES must lie in 1 .. 2**WIDTH-1");
    end

    if (PRESC_DIV < 32'd2) begin : g_bad_presc
        $error("hold_timer: PRESC_DIV must be 2 or more");
    end

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             ready_r;
    logic             busy_r;
    logic             tick_s;

`ifdef HOLD_TIMER_PRESCALE_EN
    logic presc_clr_s;

    // Restart the tick period on a clear and when a launch is accepted, so the
    // first count step lands exactly PRESC_DIV clocks after START.
    always_comb begin
        presc_clr_s = 1'b0;
        if (RESET) begin
            presc_clr_s = 1'b1;
        end else if ((state_r == T_IDLE) && START) begin
            presc_clr_s = 1'b1;
        end else begin
            presc_clr_s = 1'b0;
        end
    end

    tick_prescaler #(
        .DIV     (PRESC_DIV)
    ) u_tick_prescaler (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .CLR     (presc_clr_s),
        .TICK    (tick_s)
    );
`else
    assign tick_s = 1'b1;
`endif

    // Next-state and next-count decode; RESET wins over everything else and
    // any corrupted state or count falls back to a clean idle.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        if (RESET) begin
            state_nxt_s = T_IDLE;
            count_nxt_s = CNT_ZERO;
        end else begin
            case (state_r)
                T_IDLE: begin
                    count_nxt_s = CNT_ZERO;
                    if (START) begin
                        state_nxt_s = T_RUN;
                    end else begin
                        state_nxt_s = T_IDLE;
                    end
                end
                T_RUN: begin
                    if (!tick_s) begin
                        state_nxt_s = T_RUN;
                        count_nxt_s = count_r;
                    end else if (count_r == CNT_LAST) begin
                        state_nxt_s = T_DONE;
                        count_nxt_s = CNT_HOLD;
                    end else if (count_r < CNT_LAST) begin
                        state_nxt_s = T_RUN;
                        count_nxt_s = count_r + CNT_ONE;
                    end else begin
                        state_nxt_s = T_IDLE;
                        count_nxt_s = CNT_ZERO;
                    end
                end
                T_DONE: begin
                    state_nxt_s = T_DONE;
                    count_nxt_s = CNT_HOLD;
                end
                default: begin
                    state_nxt_s = T_IDLE;
                    count_nxt_s = CNT_ZERO;
                end
            endcase
        end
    end

    // State, count and output flags; flags are decoded from the next state so
    // they change on the same edge as the state they describe.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_r <= T_IDLE;
            count_r <= CNT_ZERO;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            ready_r <= (state_nxt_s == T_DONE);
            busy_r  <= (state_nxt_s == T_RUN);
        end
    end

    assign READY = ready_r;
    assign BUSY  = busy_r;
    assign COUNT = count_r;

endmodule

// File: tb/tb_hold_timer.sv
// -----------------------------------------------------------------------------
// tb_hold_timer
// Directed bench for hold_timer: main instance with HOLD_CYCLES=10 and a
// second instance with HOLD_CYCLES=1, plus a small controller model closing
// the RESET/START/READY loop. D is the number of clocks per counter tick.
// -----------------------------------------------------------------------------
module tb_hold_timer;

`ifdef HOLD_TIMER_PRESCALE_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif

    localparam int C_IDLE  = 0;
    localparam int C_CLR   = 1;
    localparam int C_START = 2;
    localparam int C_HOLD  = 3;
    localparam int C_DONE  = 4;

    logic       CLK;
    logic       N_RESET;
    logic       RESET;
    logic       START;
    logic       READY;
    logic       BUSY;
    logic [7:0] COUNT;
    logic       RESET1;
    logic       START1;
    logic       READY1;
    logic       BUSY1;
    logic [7:0] COUNT1;

    int checks = 0;
    int passes = 0;
    int c      = C_IDLE;
    logic rdy_seen;

    hold_timer #(
        .WIDTH       (8),
        .HOLD_CYCLES (10),
        .PRESC_DIV   (4)
    ) dut (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .RESET   (RESET),
        .START   (START),
        .READY   (READY),
        .BUSY    (BUSY),
        .COUNT   (COUNT)
    );

    hold_timer #(
        .WIDTH       (8),
        .HOLD_CYCLES (1),
        .PRESC_DIV   (4)
    ) dut1 (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .RESET   (RESET1),
        .START   (START1),
        .READY   (READY1),
        .BUSY    (BUSY1),
        .COUNT   (COUNT1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] st(input logic r, input logic b, input logic [7:0] cnt);
        return {22'd0, r, b, cnt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One controller cycle: drive Moore outputs, take an edge, then advance
    // using X and the READY value seen before that edge.
    task automatic ctrl_cycle(input logic xin);
        logic rdy;
        RESET = ((c == C_IDLE) || (c == C_CLR)) ? 1'b1 : 1'b0;
        START = (c == C_START) ? 1'b1 : 1'b0;
        rdy = READY;
        tick();
        case (c)
            C_IDLE:  c = xin ? C_CLR : C_IDLE;
            C_CLR:   c = xin ? C_START : C_IDLE;
            C_START: c = xin ? C_HOLD : C_IDLE;
            C_HOLD:  c = !xin ? C_IDLE : (rdy ? C_DONE : C_HOLD);
            C_DONE:  c = xin ? C_DONE : C_IDLE;
            default: c = C_IDLE;
        endcase
    endtask

    initial begin
        N_RESET = 1'b0;
        RESET   = 1'b0;
        START   = 1'b0;
        RESET1  = 1'b0;
        START1  = 1'b0;

        // power-on reset
        #1;
        check("por", st(READY, BUSY, COUNT), st(1'b0, 1'b0, 8'd0));
        check("por_h1", st(READY1, BUSY1, COUNT1), st(1'b0, 1'b0, 8'd0));
        tick();
        N_RESET = 1'b1;
        tick();
        tick();
        check("idle", st(READY, BUSY, COUNT), st(1'b0, 1'b0, 8'd0));

        // RESET overrides a simultaneous START in idle
        RESET = 1'b1;
        START = 1'b1;
        tick();
        RESET = 1'b0;
        START = 1'b0;
        check("rst_over_start", st(READY, BUSY, COUNT), st(1'b0, 1'b0, 8'd0));
        tick();
        check("rst_over_start_2", st(READY, BUSY, COUNT), st(1'b0, 1'b0, 8'd0));

        // basic count with an ignored START at COUNT=3
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_e0", st(READY, BUSY, COUNT), st(1'b0, 1'b1, 8'd0));
        for (int e = 1; e <= 10 * D; e++) begin
            START = (e == 3 * D + 1) ? 1'b1 : 1'b0;
            tick();
            if (e < 10 * D) begin
                check("run_step", st(READY, BUSY, COUNT), st(1'b0, 1'b1, 8'(e / D)));
            end else begin
                check("done_edge", st(READY, BUSY, COUNT), st(1'b1, 1'b0, 8'd10));
            end
        end
        START = 1'b0;

        // START in done is ignored and done is held
        START = 1'b1;
        tick();
        START = 1'b0;
        check("done_start_ign", st(READY, BUSY, COUNT), st(1'b1, 1'b0, 8'd10));
        repeat (3) tick();
        check("done_hold", st(READY, BUSY, COUNT), st(1'b1, 1'b0, 8'd10));
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("done_clear", st(READY, BUSY, COUNT), st(1'b0, 1'b0, 8'd0));

        // RESET at COUNT=5 abandons the count
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (5 * D) tick();
        check("run_c5", st(READY, BUSY, COUNT), st(1'b0, 1'b1, 8'd5));
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("run_clear", st(READY, BUSY, COUNT), st(1'b0, 1'b0, 8'd0));
        rdy_seen = 1'b0;
        for (int i = 0; i < 12 * D; i++) begin
            tick();
            rdy_seen = rdy_seen | READY;
        end
        check("no_ready", 32'(rdy_seen), 32'd0);
        check("still_idle", st(READY, BUSY, COUNT), st(1'b0, 1'b0, 8'd0));

        // restart from 0, then asynchronous reset at COUNT=7
        START = 1'b1;
        tick();
        START = 1'b0;
        check("restart0", st(READY, BUSY, COUNT), st(1'b0, 1'b1, 8'd0));
        repeat (D) tick();
        check("restart1", st(READY, BUSY, COUNT), st(1'b0, 1'b1, 8'd1));
        repeat (6 * D) tick();
        check("run_c7", st(READY, BUSY, COUNT), st(1'b0, 1'b1, 8'd7));
        #2;
        N_RESET = 1'b0;
        #1;
        check("async_rst", st(READY, BUSY, COUNT), st(1'b0, 1'b0, 8'd0));
        #2;
        N_RESET = 1'b1;
        tick();
        check("post_async", st(READY, BUSY, COUNT), st(1'b0, 1'b0, 8'd0));

        // HOLD_CYCLES=1 boundary
        START1 = 1'b1;
        tick();
        START1 = 1'b0;
        check("h1_e0", st(READY1, BUSY1, COUNT1), st(1'b0, 1'b1, 8'd0));
        repeat (D) tick();
        check("h1_done", st(READY1, BUSY1, COUNT1), st(1'b1, 1'b0, 8'd1));

        // closed loop, X held high: done one cycle after READY
        c = C_IDLE;
        for (int i = 0; i < 3 + 10 * D; i++) begin
            ctrl_cycle(1'b1);
        end
        check("loop_ready", st(READY, BUSY, COUNT), st(1'b1, 1'b0, 8'd10));
        check("loop_y_pre", 32'(c == C_DONE), 32'd0);
        ctrl_cycle(1'b1);
        check("loop_y", 32'(c == C_DONE), 32'd1);
        ctrl_cycle(1'b0);
        ctrl_cycle(1'b0);
        check("loop_clear", st(READY, BUSY, COUNT), st(1'b0, 1'b0, 8'd0));

        // closed loop, X dropped during the hold
        for (int i = 0; i < 3 + 4 * D; i++) begin
            ctrl_cycle(1'b1);
        end
        check("loop_hold_c4", st(READY, BUSY, COUNT), st(1'b0, 1'b1, 8'd4));
        ctrl_cycle(1'b0);
        check("loop_x_drop", 32'(c), 32'(C_IDLE));
        ctrl_cycle(1'b0);
        check("loop_drop_clear", st(READY, BUSY, COUNT), st(1'b0, 1'b0, 8'd0));
        RESET = 1'b0;
        START = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
